fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_pkg.sv | 14 +
 rtl/fifo_rd_skid.sv | 65 ++++++
 rtl/fifo_rd_stream.sv | 78 +++++++
 tb/tb_fifo_rd_stream.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and buffer occupancy encoding for the FIFO read-side streaming adapter.
package fifo_rd_stream_pkg;

    localparam int DATA_WIDTH = 4;
    localparam int ADDR_WIDTH = 1;
    localparam int DATA_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order buffer between the registered FIFO read data and the valid/ready output.
module fifo_rd_skid
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_rd_stream_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_en,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  pop,
    output occ_e                  occ
);

    occ_e                  occ_q, occ_d;
    logic [ADDR_WIDTH-1:0] head_q, head_d;
    logic [ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DATA_DEPTH];

    assign out_valid = (occ_q != EMPTY);
    assign out_data  = mem_q[head_q];
    assign pop       = out_valid && out_ready;
    assign occ       = occ_q;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        mem_d  = mem_q;
        if (push_en) begin
            mem_d[tail_q] = push_data;
            tail_d        = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        case ({push_en, pop})
            2'b10:   occ_d = (occ_q == EMPTY) ? ONE : TWO;
            2'b01:   occ_d = (occ_q == TWO) ? ONE : EMPTY;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DATA_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a FIFO read port into a valid/ready stream; optional delivered-word
// counter rd_cnt is built only when FIFO_RD_CNT_EN is defined.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_rd_stream_pkg::DATA_WIDTH
) (
    input  logic                  rd_clk,
    input  logic                  rd_rstn,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [7:0]            rd_cnt
`endif
);

    logic       in_flight_q, in_flight_d;
    logic       pop;
    occ_e       occ;
    logic [2:0] level;

    fifo_rd_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (rd_clk),
        .rst_n    (rd_rstn),
        .push_en  (in_flight_q),
        .push_data(fifo_rd_data),
        .out_ready(m_ready),
        .out_valid(m_valid),
        .out_data (m_data),
        .pop      (pop),
        .occ      (occ)
    );

    // Words held or arriving after this edge; a new read is issued only if a slot stays free.
    assign level = {1'b0, occ} + {2'b00, in_flight_q} - {2'b00, pop};

    always_comb begin
        fifo_rd_en  = rd_rstn && !fifo_empty && (level < 3'd2);
        in_flight_d = fifo_rd_en;
    end

    assign busy = (occ != EMPTY) || in_flight_q;

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            in_flight_q <= 1'b0;
        end else begin
            in_flight_q <= in_flight_d;
        end
    end

`ifdef FIFO_RD_CNT_EN
    logic [7:0] rd_cnt_q, rd_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q + {7'd0, pop};
    end

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rd_cnt_q <= 8'd0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized self-checking bench for fifo_rd_stream with a queue-based reference model.
module tb_fifo_rd_stream;
    import fifo_rd_stream_pkg::*;

    logic                  rd_clk = 1'b0;
    logic                  rd_rstn;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  busy;
`ifdef FIFO_RD_CNT_EN
    logic [7:0]            rd_cnt;
`endif

    fifo_rd_stream #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .rd_clk      (rd_clk),
        .rd_rstn     (rd_rstn),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en  (fifo_rd_en),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .busy        (busy)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_cnt      (rd_cnt)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    int errors = 0;
    int checks = 0;

    // Model: fifo_q = words still in the FIFO; exp_q = words read but not yet delivered.
    logic [DATA_WIDTH-1:0] fifo_q[$];
    logic [DATA_WIDTH-1:0] exp_q[$];
    bit                    force_empty;
    bit                    prev_read;
    bit                    prev_hold;
    logic [DATA_WIDTH-1:0] prev_data;
    int                    pop_total;
    int                    cyc;
    bit                    s_rd_en, s_valid, s_busy, s_pop;
    logic [DATA_WIDTH-1:0] s_data;

    task automatic reset_model();
        exp_q.delete();
        prev_read = 1'b0;
        prev_hold = 1'b0;
        pop_total = 0;
    endtask

    task automatic do_reset();
        fifo_empty  = 1'b1;
        force_empty = 1'b0;
        m_ready     = 1'b0;
        rd_rstn     = 1'b0;
        reset_model();
        repeat (2) @(negedge rd_clk);
        rd_rstn = 1'b1;
    endtask

    task automatic cycle(input bit rdy);
        bit                    rd, exp_valid, exp_rd;
        int                    lvl;
        logic [DATA_WIDTH-1:0] rd_word, dummy;
        @(negedge rd_clk);
        m_ready    = rdy;
        fifo_empty = (fifo_q.size() == 0) || force_empty;
        #1;
        s_rd_en = fifo_rd_en;
        s_valid = m_valid;
        s_data  = m_data;
        s_busy  = busy;
        exp_valid = (exp_q.size() - int'(prev_read)) != 0;
        checks++;
        if (s_valid !== exp_valid) begin
            errors++;
            $display("FAIL m_valid cyc=%0d got=%0b exp=%0b", cyc, s_valid, exp_valid);
        end
        checks++;
        if (s_busy !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, s_busy, exp_q.size() != 0);
        end
        if (exp_valid) begin
            checks++;
            if (s_data !== exp_q[0]) begin
                errors++;
                $display("FAIL m_data cyc=%0d got=%0h exp=%0h", cyc, s_data, exp_q[0]);
            end
        end
        if (prev_hold) begin
            checks++;
            if (s_valid !== 1'b1 || s_data !== prev_data) begin
                errors++;
                $display("FAIL hold cyc=%0d got=%0b/%0h exp=1/%0h", cyc, s_valid, s_data, prev_data);
            end
        end
`ifdef FIFO_RD_CNT_EN
        checks++;
        if (rd_cnt !== 8'(pop_total)) begin
            errors++;
            $display("FAIL rd_cnt cyc=%0d got=%0d exp=%0d", cyc, rd_cnt, 8'(pop_total));
        end
`endif
        s_pop  = s_valid && rdy;
        lvl    = exp_q.size() - int'(s_pop);
        exp_rd = !fifo_empty && (lvl < 2);
        checks++;
        if (s_rd_en !== exp_rd) begin
            errors++;
            $display("FAIL fifo_rd_en cyc=%0d got=%0b exp=%0b (empty=%0b)", cyc, s_rd_en, exp_rd, fifo_empty);
        end
        rd = s_rd_en && !fifo_empty;
        if (s_pop && exp_q.size() > 0) dummy = exp_q.pop_front();
        if (s_pop) pop_total++;
        rd_word = '0;
        if (rd && fifo_q.size() > 0) begin
            rd_word = fifo_q.pop_front();
            exp_q.push_back(rd_word);
        end
        checks++;
        if (exp_q.size() > 2) begin
            errors++;
            $display("FAIL outstanding cyc=%0d got=%0d exp<=2", cyc, exp_q.size());
        end
        prev_hold = s_valid && !rdy;
        prev_data = s_data;
        prev_read = rd;
        @(posedge rd_clk);
        #1;
        if (rd) fifo_rd_data = rd_word;
        cyc++;
    endtask

    task automatic test_reset();
        rd_rstn    = 1'b0;
        fifo_empty = 1'b0;
        m_ready    = 1'b1;
        @(negedge rd_clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_data !== '0 || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals got v=%0b b=%0b d=%0h en=%0b exp all 0", m_valid, busy, m_data, fifo_rd_en);
        end
`ifdef FIFO_RD_CNT_EN
        checks++;
        if (rd_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d exp=0", rd_cnt);
        end
`endif
        do_reset();
    endtask

    task automatic test_latency();
        do_reset();
        fifo_q.delete();
        fifo_q.push_back(4'h5);
        cycle(1'b1);
        checks++;
        if (s_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL lat_rd_en got=%0b exp=1", s_rd_en);
        end
        cycle(1'b1);
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_c1_valid got=%0b exp=0", s_valid);
        end
        cycle(1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_data !== 4'h5) begin
            errors++;
            $display("FAIL lat_c2 got=%0b/%0h exp=1/5", s_valid, s_data);
        end
        repeat (2) cycle(1'b1);
    endtask

    task automatic run_pops(input int n, input int first_word, input string tag);
        int cnt = 0, first = -1, last = -1;
        for (int i = 0; i < n; i++) begin
            cycle(1'b1);
            if (s_pop) begin
                checks++;
                if (s_data !== DATA_WIDTH'(first_word + cnt)) begin
                    errors++;
                    $display("FAIL %s_order got=%0h exp=%0h", tag, s_data, DATA_WIDTH'(first_word + cnt));
                end
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
        end
        checks++;
        if (cnt !== 8 || (last - first) !== 7) begin
            errors++;
            $display("FAIL %s_stream got cnt=%0d span=%0d exp cnt=8 span=7", tag, cnt, last - first);
        end
    endtask

    task automatic test_burst();
        do_reset();
        fifo_q.delete();
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DATA_WIDTH'(i));
        run_pops(14, 1, "burst");
`ifdef FIFO_RD_CNT_EN
        checks++;
        if (rd_cnt !== 8'd8) begin
            errors++;
            $display("FAIL burst_cnt got=%0d exp=8", rd_cnt);
        end
`endif
    endtask

    task automatic test_backpressure();
        int reads = 0;
        do_reset();
        fifo_q.delete();
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DATA_WIDTH'(i));
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0);
            if (s_rd_en && !fifo_empty) reads++;
        end
        checks++;
        if (reads !== 2 || s_valid !== 1'b1 || s_data !== 4'h1 || s_busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall got reads=%0d v=%0b d=%0h exp reads=2 v=1 d=1", reads, s_valid, s_data);
        end
        run_pops(12, 1, "bp");
    endtask

    task automatic test_alternating();
        int n = 24, got = 0;
        do_reset();
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(DATA_WIDTH'($urandom));
        for (int i = 0; i < 70; i++) begin
            cycle(i[0]);
            if (s_pop) got++;
        end
        checks++;
        if (got !== n || fifo_q.size() != 0) begin
            errors++;
            $display("FAIL alt_count got=%0d exp=%0d", got, n);
        end
    endtask

    task automatic test_random();
        int pushed = 0, got = 0;
        do_reset();
        fifo_q.delete();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                fifo_q.push_back(DATA_WIDTH'($urandom));
                pushed++;
            end
            force_empty = ($urandom_range(0, 3) == 0);
            cycle($urandom_range(0, 1) == 1);
            if (s_pop) got++;
        end
        force_empty = 1'b0;
        for (int i = 0; i < 400 && (fifo_q.size() != 0 || exp_q.size() != 0); i++) begin
            cycle(1'b1);
            if (s_pop) got++;
        end
        checks++;
        if (got !== pushed) begin
            errors++;
            $display("FAIL rand_count got=%0d exp=%0d", got, pushed);
        end
    endtask

    task automatic test_reset_mid();
        logic [DATA_WIDTH-1:0] first_exp;
        bit seen = 0;
        do_reset();
        fifo_q.delete();
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DATA_WIDTH'(i));
        repeat (4) cycle(1'b1);
        repeat (4) cycle(1'b0);
        checks++;
        if (s_valid !== 1'b1 || s_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_full got v=%0b b=%0b exp 1/1", s_valid, s_busy);
        end
        #2;
        rd_rstn = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_data !== '0) begin
            errors++;
            $display("FAIL mid_reset got v=%0b b=%0b d=%0h exp 0/0/0", m_valid, busy, m_data);
        end
`ifdef FIFO_RD_CNT_EN
        checks++;
        if (rd_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_cnt got=%0d exp=0", rd_cnt);
        end
`endif
        fifo_empty = 1'b1;
        reset_model();
        @(negedge rd_clk);
        rd_rstn = 1'b1;
        first_exp = fifo_q[0];
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1);
            if (s_pop && !seen) begin
                seen = 1;
                checks++;
                if (s_data !== first_exp) begin
                    errors++;
                    $display("FAIL mid_first got=%0h exp=%0h", s_data, first_exp);
                end
            end
        end
    endtask

`ifdef FIFO_RD_CNT_EN
    task automatic test_wrap();
        do_reset();
        fifo_q.delete();
        for (int i = 0; i < 257; i++) fifo_q.push_back(DATA_WIDTH'($urandom));
        for (int i = 0; i < 265; i++) cycle(1'b1);
        checks++;
        if (rd_cnt !== 8'd1 || pop_total !== 257) begin
            errors++;
            $display("FAIL wrap got=%0d pops=%0d exp=1 pops=257", rd_cnt, pop_total);
        end
    endtask
`endif

    initial begin
        cyc          = 0;
        fifo_rd_data = '0;
        force_empty  = 1'b0;
        reset_model();
        test_reset();
        test_latency();
        test_burst();
        test_backpressure();
        test_alternating();
        test_random();
        test_reset_mid();
`ifdef FIFO_RD_CNT_EN
        test_wrap();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
